ieee_fpu_accum: RTL
===================

Name: ieee_fpu_accum

Overview:
- IEEE-754 single-precision accumulator directly downstream of the FP multiplier in the CNN MAC datapath.
- Consumes one 32-bit product per handshake and sums TERMS products (one kernel window).
- Emits the sum with a one-cycle valid pulse, then auto-clears for the next window.
- Multi-cycle FSM: align, add, normalise. Truncation rounding, same as the multiplier.

Parameters:
- TERMS, 9, number of products summed per output (3x3 kernel); legal range 1..2**CNT_W.
- CNT_W, 4, width of the term counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product on in_data is valid.
- in_data  in  32  IEEE-754 single product (sign[31], exp[30:23], mant[22:0]).
- in_ready  out  1  block can accept an operand this cycle.
- out_valid  out  1  one-cycle pulse; out_data holds the window sum.
- out_data  out  32  accumulated sum; holds its value until the next out_valid.
- out_ovf  out  1  valid with out_valid; window saturated to infinity by overflow.
- busy  out  1  FSM not in IDLE, or count != 0.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, acc=0x00000000, count=0, ovf_sticky=0, out_valid=0, out_data=0, out_ovf=0, in_ready=1 the following cycle.
- rst overrides every state, including mid-operation. A partial window is discarded and never output.
- States:
  - IDLE: in_ready=1. When in_valid&in_ready, latch in_data and go to ALIGN.
  - ALIGN: unpack acc and operand, adding the hidden 1. Exp 0 is flushed to zero (denormals treated as 0). Swap so the larger magnitude is first. Right-shift the smaller 24-bit mantissa by the exponent difference; shifted-out bits are dropped; a difference >= 25 gives 0.
  - ADD: 25-bit add if signs are equal, else subtract smaller from larger. Result sign = sign of the larger operand.
  - NORM:
    - Carry out: shift right 1, exp+1.
    - Otherwise left-shift until bit 23 is set, decrementing exp.
    - Zero mantissa gives +0.0.
    - exp >= 255 gives signed infinity and sets ovf_sticky.
    - exp <= 0 gives +0.0.
    - Write acc, count+1, return to IDLE.
- Timing: operand accepted in cycle T. in_ready is low in T+1..T+3 and high again in T+4. Throughput is 1 operand per 4 cycles.
- Window end: when the NORM write is the TERMS-th term, in cycle T+4:
  - out_valid=1, out_data=new acc, out_ovf=ovf_sticky.
  - Same edge clears acc to +0, count to 0, ovf_sticky to 0.
  - in_ready=1 in the same cycle. A new operand may be accepted while out_valid is high.
- Specials:
  - Operand exp=255 with acc finite: acc becomes the operand unchanged.
  - acc inf and operand finite: acc unchanged.
  - inf + opposite-sign inf, or any NaN operand: acc=0x7FC00000, sticky until window end.
  - Specials still take the full 4 cycles and count as a term.
- in_valid while in_ready=0 is ignored. The upstream stage must hold data until in_ready.
- No backpressure on the output. out_valid is not gated by any downstream ready.
- Sign of exact zero is always +.

Test Plan:
- TERMS=9, nine operands 0x3F800000 (1.0), in_valid held high. Required: accepts every 4 cycles; out_valid for exactly one cycle, 4 cycles after the 9th acceptance; out_data=0x41100000 (9.0); out_ovf=0.
- Cancellation: 0x3FC00000, 0xBFC00000, then seven 0x00000000. Required: out_data=0x00000000.
- Alignment and truncation:
  - Window 1: 0x4B000000 (2^23) + 0x3F800000, then seven zeros. Required: 0x4B000001.
  - Window 2: 0x4B800000 (2^24) + 0x3F800000, then seven zeros. Required: 0x4B800000 (LSB truncated).
- Overflow: 0x7F7FFFFF twice, then seven zeros. Required: out_data=0x7F800000, out_ovf=1. Next window of nine 1.0 gives 0x41100000 with out_ovf=0.
- Specials: 0x7F800000 + 0xFF800000, then seven 1.0. Required: out_data=0x7FC00000.
- Reset mid-op: after 3 accepted 1.0 operands, pulse rst during ADD. Required: next cycle in_ready=1, out_valid=0, busy=0. A following nine 1.0 gives exactly 0x41100000. With in_valid held during ALIGN/ADD/NORM, no extra terms are counted.

Source files
------------

// File: rtl/ieee_fpu_accum_if.sv
// ieee_fpu_accum_if: operand/result bundle for the FP window accumulator.
//   in_valid, in_data  - product handshake from the upstream multiplier
//   in_ready           - accumulator can take an operand this cycle
//   out_valid          - one-cycle pulse, out_data/out_ovf carry the window sum
//   out_data, out_ovf  - window sum and overflow flag, held until the next pulse
//   busy               - accumulator not idle or holding a partial window
// master: producer/observer side; slave: accumulator side.
interface ieee_fpu_accum_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/ieee_fpu_accum.sv
// ieee_fpu_accum: IEEE-754 single-precision accumulator summing TERMS products per window.
// Each operand goes IDLE -> ALIGN -> ADD -> NORM (4 cycles), truncating throughout.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset, discards any partial window
//   bus_io - operand handshake, window result and busy flag (slave side)
module ieee_fpu_accum #(
    parameter int unsigned TERMS = 9,
    parameter int unsigned CNT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    ieee_fpu_accum_if.slave bus_io
);

    localparam logic [31:0]      QNan    = 32'h7FC0_0000;
    localparam logic [CNT_W:0]   LastCnt = (CNT_W + 1)'(TERMS);

    typedef enum logic [1:0] {StIdle, StAlign, StAdd, StNorm} state_e;

    state_e           state_q, state_d;
    logic [31:0]      op_q, op_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    // Stage registers between ALIGN, ADD and NORM
    logic [7:0]       exp_q, exp_d;
    logic             sign_q, sign_d;
    logic             sub_q, sub_d;
    logic [23:0]      big_q, big_d;
    logic [23:0]      small_q, small_d;
    logic [24:0]      sum_q, sum_d;
    logic             spec_q, spec_d;
    logic [31:0]      spec_val_q, spec_val_d;

    // Alignment datapath, driven from acc_q/op_q
    logic [7:0]  a_exp, o_exp, big_exp, small_exp, exp_diff;
    logic [23:0] a_man, o_man, big_man, small_man, small_shift;
    logic        a_nan, a_inf, o_nan, o_inf, op_big;
    logic        al_spec;
    logic [31:0] al_spec_val;

    always_comb begin
        a_exp = acc_q[30:23];
        o_exp = op_q[30:23];
        // Exponent 0 is flushed to zero, so no hidden bit there
        a_man = (a_exp == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};
        o_man = (o_exp == 8'd0) ? 24'd0 : {1'b1, op_q[22:0]};
        a_nan = (a_exp == 8'hFF) && (acc_q[22:0] != 23'd0);
        a_inf = (a_exp == 8'hFF) && (acc_q[22:0] == 23'd0);
        o_nan = (o_exp == 8'hFF) && (op_q[22:0] != 23'd0);
        o_inf = (o_exp == 8'hFF) && (op_q[22:0] == 23'd0);

        op_big    = {o_exp, o_man} > {a_exp, a_man};
        big_exp   = op_big ? o_exp : a_exp;
        small_exp = op_big ? a_exp : o_exp;
        big_man   = op_big ? o_man : a_man;
        small_man = op_big ? a_man : o_man;
        exp_diff  = big_exp - small_exp;
        small_shift = (exp_diff >= 8'd25) ? 24'd0 : (small_man >> exp_diff);

        al_spec     = 1'b1;
        al_spec_val = QNan;
        if (o_nan || a_nan || (o_inf && a_inf && (acc_q[31] != op_q[31]))) begin
            al_spec_val = QNan;
        end else if (o_inf) begin
            al_spec_val = op_q;
        end else if (a_inf) begin
            al_spec_val = acc_q;
        end else begin
            al_spec = 1'b0;
        end
    end

    // Normalisation datapath, driven from sum_q/exp_q
    logic [4:0]        lz;
    logic [23:0]       norm_man;
    logic signed [9:0] norm_exp;
    logic [31:0]       norm_res;
    logic              norm_ovf;

    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (sum_q[i]) begin
                lz = 5'(23 - i);
            end
        end
        if (sum_q[24]) begin
            norm_man = sum_q[24:1];
            norm_exp = $signed({2'b00, exp_q}) + 10'sd1;
        end else begin
            norm_man = sum_q[23:0] << lz;
            norm_exp = $signed({2'b00, exp_q}) - $signed({5'd0, lz});
        end
        norm_ovf = 1'b0;
        // After normalising, bit 23 is clear only for an all-zero sum
        if (!norm_man[23]) begin
            norm_res = 32'd0;
        end else if (norm_exp >= 10'sd255) begin
            norm_res = {sign_q, 8'hFF, 23'd0};
            norm_ovf = 1'b1;
        end else if (norm_exp <= 10'sd0) begin
            norm_res = 32'd0;
        end else begin
            norm_res = {sign_q, norm_exp[7:0], norm_man[22:0]};
        end
    end

    logic [CNT_W:0] cnt_inc;
    logic [31:0]    result;
    logic           ovf_now;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        sub_d       = sub_q;
        big_d       = big_q;
        small_d     = small_q;
        sum_d       = sum_q;
        spec_d      = spec_q;
        spec_val_d  = spec_val_q;
        cnt_inc     = {1'b0, count_q} + 1'b1;
        result      = spec_q ? spec_val_q : norm_res;
        ovf_now     = !spec_q && norm_ovf;

        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    op_d    = bus_io.in_data;
                    state_d = StAlign;
                end
            end
            StAlign: begin
                exp_d      = big_exp;
                sign_d     = op_big ? op_q[31] : acc_q[31];
                sub_d      = op_q[31] != acc_q[31];
                big_d      = big_man;
                small_d    = small_shift;
                spec_d     = al_spec;
                spec_val_d = al_spec_val;
                state_d    = StAdd;
            end
            StAdd: begin
                sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                : ({1'b0, big_q} + {1'b0, small_q});
                state_d = StNorm;
            end
            StNorm: begin
                state_d = StIdle;
                if (cnt_inc == LastCnt) begin
                    out_valid_d = 1'b1;
                    out_data_d  = result;
                    out_ovf_d   = ovf_q | ovf_now;
                    acc_d       = 32'd0;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                end else begin
                    acc_d   = result;
                    count_d = cnt_inc[CNT_W-1:0];
                    ovf_d   = ovf_q | ovf_now;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= 32'd0;
            acc_q       <= 32'd0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_ovf_q   <= 1'b0;
            exp_q       <= 8'd0;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            big_q       <= 24'd0;
            small_q     <= 24'd0;
            sum_q       <= 25'd0;
            spec_q      <= 1'b0;
            spec_val_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            sub_q       <= sub_d;
            big_q       <= big_d;
            small_q     <= small_d;
            sum_q       <= sum_d;
            spec_q      <= spec_d;
            spec_val_q  <= spec_val_d;
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle);
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.out_ovf   = out_ovf_q;
    assign bus_io.busy      = (state_q != StIdle) || (count_q != '0);

endmodule
